tmp_conv_sequencer: RTL and testbench
=====================================

TMP_CONV_SEQUENCER -- requirements
Module: tmp_conv_sequencer

Interface
REQ-001 SHALL have parameter CONV_BASE, default 8: conversion length in Clk cycles at 9-bit resolution; must be a power of two, minimum 2.
REQ-002 SHALL have port Clk, input, 1 bit: the only clock; all logic updates on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port Shutdown, input, 1 bit: configuration SD bit; 1 selects shutdown mode, 0 selects continuous mode.
REQ-005 SHALL have port OneShot, input, 1 bit: configuration OS bit; requests a single conversion while in shutdown.
REQ-006 SHALL have port Resolution, input, 2 bits: 00 = 9-bit, 01 = 10-bit, 10 = 11-bit, 11 = 12-bit.
REQ-007 SHALL have port Sample_In, input, 12 bits: raw ADC code.
REQ-008 SHALL have port Temperature_Out, output, 12 bits: last completed conversion; feeds the alert slave Temperature_In.
REQ-009 SHALL have port Conv_Done, output, 1 bit: one-cycle pulse when Temperature_Out updates.
REQ-010 SHALL have port Busy, output, 1 bit: 1 while a conversion is in progress.
REQ-011 SHALL have port OneShot_Clear, output, 1 bit: one-cycle pulse instructing the configuration register to clear the OS bit.

Function
REQ-012 SHALL implement exactly two states: SHUTDOWN and CONVERT.
REQ-013 SHALL latch Resolution into R_lat on entry to CONVERT; a Resolution change mid-conversion SHALL take effect only at the next conversion.
REQ-014 SHALL set conversion length N = CONV_BASE << R_lat cycles, i.e. 8/16/32/64 at the default CONV_BASE.
REQ-015 SHALL reset the cycle counter to 0 on entry to CONVERT and increment it by 1 per CONVERT cycle; the counter SHALL be wide enough for 8*CONV_BASE-1 without wrap.
REQ-016 SHALL, on the edge ending the cycle where counter == N-1, capture Sample_In truncated to resolution: the low (3 - R_lat) bits are forced to 0 and the upper bits pass unchanged.
REQ-017 SHALL drive Temperature_Out and Conv_Done = 1 on that same edge, so both are visible in the following cycle; Conv_Done SHALL be 0 on all other cycles.
REQ-018 SHALL, at the end of a conversion, re-enter CONVERT with the counter at 0 when Shutdown = 0 and the conversion was not a one-shot; otherwise it SHALL enter SHUTDOWN.
REQ-019 SHALL make back-to-back continuous conversions gapless: Conv_Done period is exactly N cycles.
REQ-020 SHALL, when Shutdown rises mid-conversion, complete the current conversion and then enter SHUTDOWN; no truncated result is produced.
REQ-021 SHALL, in SHUTDOWN with Shutdown = 0, enter CONVERT on the next edge.
REQ-022 SHALL, in SHUTDOWN with Shutdown = 1 and OneShot = 1, enter CONVERT with the one-shot flag set and pulse OneShot_Clear for exactly one cycle, coincident with Busy rising.
REQ-023 SHALL, at the end of a one-shot conversion, return to SHUTDOWN regardless of Shutdown.
REQ-024 SHALL ignore OneShot while in CONVERT and while Shutdown = 0; OneShot_Clear SHALL NOT pulse in those cases.
REQ-025 SHALL drive Busy = 1 exactly in CONVERT; Temperature_Out SHALL hold its value in SHUTDOWN.

Reset
REQ-026 SHALL, on RST = 1 at an edge: state = SHUTDOWN, counter = 0, R_lat = 00, one-shot flag = 0, Temperature_Out = 12'h000, Conv_Done = 0, Busy = 0, OneShot_Clear = 0.
REQ-027 SHALL let reset mid-conversion abort it with no Conv_Done pulse and no Temperature_Out update.
REQ-028 SHALL give RST priority over all other inputs; the first post-reset CONVERT entry SHALL occur on the first edge after RST falls when Shutdown = 0.

Verification
REQ-029 SHALL verify continuous mode: CONV_BASE = 8, Resolution = 00, Shutdown = 0, Sample_In = 12'hABC, RST released -> first Conv_Done 9 cycles after release, then every 8 cycles, Temperature_Out = 12'hAB8.
REQ-030 SHALL verify full resolution: Resolution = 11, Sample_In = 12'hABC -> Conv_Done period 64, Temperature_Out = 12'hABC; Resolution = 01 -> 12'hABC, period 16.
REQ-031 SHALL verify mid-conversion resolution change: Resolution 00 -> 11 at counter = 3 -> current conversion ends at 8 cycles with 12'hAB8; the next conversion lasts 64 cycles and yields 12'hABC.
REQ-032 SHALL verify shutdown entry: Shutdown raised at counter = 2 -> Conv_Done at the normal end, then Busy = 0 and Temperature_Out held for 100 cycles.
REQ-033 SHALL verify one-shot: in SHUTDOWN, OneShot = 1 held for 3 cycles -> exactly one OneShot_Clear pulse, one conversion, one Conv_Done, then SHUTDOWN.
REQ-034 SHALL verify reset mid-conversion: RST at counter = 5 -> next cycle all outputs 0, no Conv_Done.

Source files
------------

// File: rtl/tmp_conv_sequencer.sv
// Temperature conversion sequencer: runs timed ADC conversions in continuous or
// one-shot mode and publishes the truncated result with a one-cycle done pulse.
//
// state    | meaning
// SHUTDOWN | idle, Temperature_Out held, waiting for continuous or one-shot start
// CONVERT  | conversion in progress, counter runs up to N-1
module tmp_conv_sequencer #(
  parameter int CONV_BASE = 8
) (
  input  logic        Clk,
  input  logic        RST,
  input  logic        Shutdown,
  input  logic        OneShot,
  input  logic [1:0]  Resolution,
  input  logic [11:0] Sample_In,
  output logic [11:0] Temperature_Out,
  output logic        Conv_Done,
  output logic        Busy,
  output logic        OneShot_Clear
);

  localparam int CW = $clog2(8 * CONV_BASE);

  typedef enum logic {
    SHUTDOWN = 1'b0,
    CONVERT  = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    r_lat;
  logic          one_shot;

  logic [CW:0]   n_last;
  logic [11:0]   mask;
  logic          conv_end;

  // One extra bit so CONV_BASE << 3 does not wrap before the -1.
  always_comb begin
    n_last   = ((CW+1)'(CONV_BASE) << r_lat) - (CW+1)'(1);
    mask     = 12'hFFF << (2'd3 - r_lat);
    conv_end = ({1'b0, cnt} == n_last);
  end

  always_ff @(posedge Clk) begin
    if (RST) begin
      state           <= SHUTDOWN;
      cnt             <= '0;
      r_lat           <= 2'b00;
      one_shot        <= 1'b0;
      Temperature_Out <= 12'h000;
      Conv_Done       <= 1'b0;
      Busy            <= 1'b0;
      OneShot_Clear   <= 1'b0;
    end else begin
      Conv_Done     <= 1'b0;
      OneShot_Clear <= 1'b0;
      case (state)
        SHUTDOWN: begin
          if (!Shutdown) begin
            state    <= CONVERT;
            Busy     <= 1'b1;
            cnt      <= '0;
            r_lat    <= Resolution;
            one_shot <= 1'b0;
          end else if (OneShot) begin
            state         <= CONVERT;
            Busy          <= 1'b1;
            cnt           <= '0;
            r_lat         <= Resolution;
            one_shot      <= 1'b1;
            OneShot_Clear <= 1'b1;
          end
        end
        CONVERT: begin
          if (conv_end) begin
            Temperature_Out <= Sample_In & mask;
            Conv_Done       <= 1'b1;
            cnt             <= '0;
            // Restart in the same edge so continuous conversions are gapless.
            if (!Shutdown && !one_shot) begin
              r_lat <= Resolution;
            end else begin
              state    <= SHUTDOWN;
              Busy     <= 1'b0;
              one_shot <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmp_conv_sequencer.sv
// Bench for tmp_conv_sequencer: cycle-level conversion model checked every cycle,
// plus directed scenarios with hand-computed latencies, periods and results.
module tb_tmp_conv_sequencer;

  localparam int CONV_BASE = 8;

  logic        Clk = 1'b0;
  logic        RST = 1'b1;
  logic        Shutdown = 1'b0;
  logic        OneShot = 1'b0;
  logic [1:0]  Resolution = 2'b00;
  logic [11:0] Sample_In = 12'hABC;
  logic [11:0] Temperature_Out;
  logic        Conv_Done;
  logic        Busy;
  logic        OneShot_Clear;

  tmp_conv_sequencer #(.CONV_BASE(CONV_BASE)) dut (
    .Clk(Clk),
    .RST(RST),
    .Shutdown(Shutdown),
    .OneShot(OneShot),
    .Resolution(Resolution),
    .Sample_In(Sample_In),
    .Temperature_Out(Temperature_Out),
    .Conv_Done(Conv_Done),
    .Busy(Busy),
    .OneShot_Clear(OneShot_Clear)
  );

  always #5 Clk = ~Clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: a conversion is "cycles remaining" plus the resolution it started with.
  bit          m_busy = 0, m_one = 0, m_done = 0, m_clr = 0;
  int          m_left = 0, m_res = 0;
  logic [11:0] m_temp = '0;
  bit          chk_en = 0;

  function automatic void m_start(input bit os);
    m_busy = 1;
    m_one  = os;
    m_res  = int'(Resolution);
    m_left = CONV_BASE << m_res;
  endfunction

  always @(posedge Clk) begin
    m_done = 0;
    m_clr  = 0;
    if (RST) begin
      m_busy = 0; m_one = 0; m_left = 0; m_temp = '0;
    end else if (!m_busy) begin
      if (!Shutdown) m_start(0);
      else if (OneShot) begin
        m_start(1);
        m_clr = 1;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_temp = (Sample_In >> (3 - m_res)) << (3 - m_res);
        m_done = 1;
        if (!Shutdown && !m_one) m_start(0);
        else begin
          m_busy = 0;
          m_one  = 0;
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("model_busy", Busy, m_busy);
      chk("model_done", Conv_Done, m_done);
      chk("model_clr", OneShot_Clear, m_clr);
      chk("model_temp", Temperature_Out, m_temp);
    end
  end

  // Counts falling edges until Conv_Done is seen, bounded.
  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(negedge Clk);
      cycles++;
    end while (!Conv_Done && cycles < 200);
    if (cycles >= 200) chk("done_timeout", Conv_Done, 1);
  endtask

  int c, n_clr, n_done, n_bad;

  initial begin
    repeat (3) @(negedge Clk);
    chk_en = 1;
    chk("rst_busy", Busy, 0);
    chk("rst_done", Conv_Done, 0);
    chk("rst_clr", OneShot_Clear, 0);
    chk("rst_temp", Temperature_Out, 12'h000);

    // Continuous, 9-bit
    RST = 1'b0;
    wait_done(c); chk("first_latency", c, 9);  chk("first_temp", Temperature_Out, 12'hAB8);
    wait_done(c); chk("period_9b", c, 8);      chk("temp_9b", Temperature_Out, 12'hAB8);

    // Resolution change at counter 3
    repeat (3) @(negedge Clk);
    Resolution = 2'b11;
    wait_done(c); chk("midchg_len", c, 5);     chk("midchg_temp", Temperature_Out, 12'hAB8);
    wait_done(c); chk("period_12b", c, 64);    chk("temp_12b", Temperature_Out, 12'hABC);
    Resolution = 2'b01;
    wait_done(c); chk("period_12b_2", c, 64);  chk("temp_12b_2", Temperature_Out, 12'hABC);
    wait_done(c); chk("period_10b", c, 16);    chk("temp_10b", Temperature_Out, 12'hABC);

    Sample_In = 12'h5A7;
    Resolution = 2'b00;
    wait_done(c); chk("period_10b_2", c, 16);  chk("temp_10b_5a7", Temperature_Out, 12'h5A4);
    wait_done(c); chk("period_9b_2", c, 8);    chk("temp_9b_5a7", Temperature_Out, 12'h5A0);
    Resolution = 2'b10;
    wait_done(c); chk("period_9b_3", c, 8);    chk("temp_9b_5a7_2", Temperature_Out, 12'h5A0);
    wait_done(c); chk("period_11b", c, 32);    chk("temp_11b_5a7", Temperature_Out, 12'h5A6);

    // Shutdown raised at counter 2: conversion still completes
    repeat (2) @(negedge Clk);
    Shutdown = 1'b1;
    wait_done(c); chk("sd_len", c, 30);        chk("sd_temp", Temperature_Out, 12'h5A6);
    n_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (Busy !== 1'b0 || Conv_Done !== 1'b0 || Temperature_Out !== 12'h5A6) n_bad++;
    end
    chk("sd_hold_bad_cycles", n_bad, 0);

    // One-shot held for 3 cycles
    Resolution = 2'b01;
    Sample_In  = 12'h123;
    OneShot    = 1'b1;
    n_clr = 0; n_done = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (i == 0) begin
        chk("os_busy_rise", Busy, 1);
        chk("os_clr_rise", OneShot_Clear, 1);
      end
      if (OneShot_Clear === 1'b1) n_clr++;
      if (Conv_Done === 1'b1) n_done++;
      if (i == 2) OneShot = 1'b0;
    end
    chk("os_clr_count", n_clr, 1);
    chk("os_done_count", n_done, 1);
    chk("os_busy_end", Busy, 0);
    chk("os_temp", Temperature_Out, 12'h120);

    // Reset at counter 5
    Shutdown   = 1'b0;
    Resolution = 2'b00;
    Sample_In  = 12'hABC;
    @(negedge Clk);
    chk("rm_busy_start", Busy, 1);
    repeat (5) @(negedge Clk);
    RST = 1'b1;
    @(negedge Clk);
    chk("rm_busy", Busy, 0);
    chk("rm_done", Conv_Done, 0);
    chk("rm_clr", OneShot_Clear, 0);
    chk("rm_temp", Temperature_Out, 12'h000);
    n_done = 0;
    repeat (3) begin
      @(negedge Clk);
      if (Conv_Done === 1'b1) n_done++;
    end
    chk("rm_no_done", n_done, 0);
    RST = 1'b0;
    wait_done(c); chk("rm_relatency", c, 9);   chk("rm_retemp", Temperature_Out, 12'hAB8);

    @(negedge Clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
